// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage for the FFT core: accepts frames in bit-reversed index
// order and re-emits them in natural order through a two-bank ping-pong buffer.
module fft_bitrev_reorder #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2N = 4,
  parameter int unsigned DW    = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [2*DW-1:0]     in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DW-1:0]     out_data,
  output logic [LOG2N-1:0]    out_index,
  output logic                out_last,
  output logic                sof_err
);

  localparam int unsigned SW = 2 * DW;
  localparam int unsigned AW = LOG2N + 1;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  bank_state_t bank_q [2];
  bank_state_t bank_d [2];

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;

  logic             wr_en;
  logic             rd_en;
  logic             restart;
  logic             wr_last;
  logic             rd_last;
  logic [LOG2N-1:0] wr_addr;

  logic [SW-1:0] mem [2*N];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r[i] = k[int'(LOG2N) - 1 - i];
    end
    return r;
  endfunction

  // Handshake decode; in_ready depends on state registers only
  always_comb begin
    in_ready = 1'b1;
    wr_en    = 1'b0;
    restart  = 1'b0;
    wr_addr  = '0;
    wr_last  = 1'b0;
    rd_en    = 1'b0;
    rd_last  = 1'b0;
    if (bank_q[wr_bank] == BANK_FULL || bank_q[wr_bank] == BANK_DRAINING) begin
      in_ready = 1'b0;
    end
    wr_en   = in_valid && in_ready;
    restart = in_sof && (wr_cnt != '0);
    wr_addr = restart ? '0 : bitrev(wr_cnt);
    wr_last = !restart && (wr_cnt == LAST_IDX);
    rd_en   = (!out_valid || out_ready) &&
              (bank_q[rd_bank] == BANK_FULL || bank_q[rd_bank] == BANK_DRAINING);
    rd_last = (rd_cnt == LAST_IDX);
  end

  // Bank next-state; writer and reader never target the same bank at once
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_en && (wr_bank == 1'(b))) begin
        bank_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
      end
      if (rd_en && (rd_bank == 1'(b))) begin
        bank_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // Write pointer; an early in_sof restarts the frame at k=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      sof_err <= 1'b0;
    end else begin
      sof_err <= wr_en && restart;
      if (wr_en) begin
        if (restart) begin
          wr_cnt <= LOG2N'(1);
        end else if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + LOG2N'(1);
        end
      end
    end
  end

  // Sample storage needs no reset; bank state tracks validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= in_data;
    end
  end

  // Output register: reload when empty or being consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        out_valid <= 1'b1;
        out_data  <= mem[AW'({rd_bank, rd_cnt})];
        out_index <= rd_cnt;
        out_last  <= rd_last;
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + LOG2N'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: scoreboard of natural-order
// frames built from the bit-reversed input stream.
module tb_fft_bitrev_reorder;

  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned DW    = 17;
  localparam int unsigned SW    = 2 * DW;

  typedef struct packed {
    logic [SW-1:0]    data;
    logic [LOG2N-1:0] index;
    logic             last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_sof;
  logic [SW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             sof_err;

  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  exp_t          sb_q[$];
  int            xfer_cyc[$];
  logic [SW-1:0] m_frame [N];
  int            m_cnt = 0;
  int            sof_err_seen = 0;
  int            stall_cnt = 0;
  int            ready_mode = 0;
  logic [SW-1:0] last_idx0_data = '0;
  exp_t          mon_e;

  function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = k[int'(LOG2N) - 1 - i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern: 0 = always ready, 1 = never ready, 2 = random
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: pops and compares every transferred sample
  always @(negedge clk) begin
    if (sof_err === 1'b1) sof_err_seen++;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      xfer_cyc.push_back(cyc);
      if (out_index == '0) last_idx0_data = out_data;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got index=%0d data=%h, expected no output", out_index, out_data);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (out_data !== mon_e.data) begin
          errors++;
          $display("FAIL out_data: got %h expected %h (index %0d)", out_data, mon_e.data, mon_e.index);
        end
        checks++;
        if (out_index !== mon_e.index) begin
          errors++;
          $display("FAIL out_index: got %0d expected %0d", out_index, mon_e.index);
        end
        checks++;
        if (out_last !== mon_e.last) begin
          errors++;
          $display("FAIL out_last: got %b expected %b (index %0d)", out_last, mon_e.last, mon_e.index);
        end
      end
    end
  end

  // Present one sample, wait for acceptance, update the reference frame
  task automatic send_sample(input logic [SW-1:0] d, input logic sof);
    int   waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 500) begin
      stall_cnt++;
      waited++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end else begin
      if (sof && m_cnt != 0) m_cnt = 0;
      m_frame[rev(LOG2N'(m_cnt))] = d;
      m_cnt++;
      if (m_cnt == int'(N)) begin
        for (int i = 0; i < int'(N); i++) begin
          e.data  = m_frame[i];
          e.index = LOG2N'(i);
          e.last  = (i == int'(N) - 1);
          sb_q.push_back(e);
        end
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid === 1'b1) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (sb_q.size() == 0) && (out_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    out_ready = 1'b1; ready_mode = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_index !== '0) begin errors++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err: got %b expected 0", sof_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [LOG2N-1:0] r;
    bit ok;
    for (int k = 0; k < int'(N); k++) begin
      r = rev(LOG2N'(k));
      send_sample({DW'(r), DW'(-int'(r))}, k == 0);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b expected 1", out_valid); end
    checks++; if (out_index !== '0) begin errors++; $display("FAIL basic_first_index: got %0d expected 0", out_index); end
    checks++; if (out_data !== {DW'(0), DW'(0)}) begin errors++; $display("FAIL basic_first_data: got %h expected 0", out_data); end
    wait_drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_drain: %0d outputs still pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    stall_cnt = 0;
    xfer_cyc.delete();
    for (int k = 0; k < 3 * int'(N); k++) begin
      send_sample(SW'({$urandom(), $urandom()}), (k % int'(N)) == 0);
    end
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: %0d outputs pending, expected 0", sb_q.size()); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_in_ready: stalled %0d cycles, expected 0", stall_cnt); end
    checks++;
    if (xfer_cyc.size() != 3 * int'(N)) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected %0d", xfer_cyc.size(), 3 * N);
    end else if (xfer_cyc[3*N-1] - xfer_cyc[0] != 3 * int'(N) - 1) begin
      errors++; $display("FAIL b2b_contiguous: span %0d cycles expected %0d", xfer_cyc[3*N-1] - xfer_cyc[0], 3 * N - 1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    ready_mode = 1;
    @(posedge clk);
    #1;
    stall_cnt = 0;
    for (int k = 0; k < 2 * int'(N); k++) begin
      send_sample(SW'({$urandom(), $urandom()}), (k % int'(N)) == 0);
    end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL bp_early_stall: %0d stall cycles within 32 samples, expected 0", stall_cnt); end
    in_valid = 1'b1; in_sof = 1'b1; in_data = '0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_33: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
      checks++; if (out_index !== '0) begin errors++; $display("FAIL bp_hold_index: got %0d expected 0", out_index); end
      checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL bp_hold_data: got %h with no frame queued", out_data);
      end else if (out_data !== sb_q[0].data) begin
        errors++; $display("FAIL bp_hold_data: got %h expected %h", out_data, sb_q[0].data);
      end
      @(negedge clk);
    end
    ready_mode = 0;
    for (int k = 0; k < int'(N); k++) begin
      send_sample(SW'({$urandom(), $urandom()}), k == 0);
    end
    wait_drain(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d outputs pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_sof_restart();
    bit ok;
    int seen0;
    seen0 = sof_err_seen;
    for (int k = 0; k < 5; k++) send_sample(SW'(34'h2_0000_0000 + k), k == 0);
    send_sample({17'h1FFFF, 17'h10000}, 1'b1);
    for (int k = 1; k < int'(N); k++) send_sample(SW'(34'h0_0000_1000 + k), 1'b0);
    wait_drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sof_drain: %0d outputs pending, expected 0", sb_q.size()); end
    checks++; if (sof_err_seen - seen0 !== 1) begin errors++; $display("FAIL sof_err_pulses: got %0d expected 1", sof_err_seen - seen0); end
    checks++; if (last_idx0_data !== {17'h1FFFF, 17'h10000}) begin errors++; $display("FAIL sof_first_sample: got %h expected %h", last_idx0_data, {17'h1FFFF, 17'h10000}); end
  endtask

  task automatic test_random();
    bit ok;
    logic [SW-1:0] d;
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < int'(N); k++) begin
        case (k)
          3:       d = '1;
          7:       d = '0;
          11:      d = {17'h10000, 17'h0FFFF};
          default: d = SW'({$urandom(), $urandom()});
        endcase
        send_sample(d, k == 0);
      end
    end
    wait_drain(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_drain: %0d outputs pending, expected 0", sb_q.size()); end
    ready_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int k = 0; k < int'(N) + 6; k++) begin
      send_sample(SW'({$urandom(), $urandom()}), (k % int'(N)) == 0);
    end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", out_data); end
    checks++; if (out_index !== '0) begin errors++; $display("FAIL midrst_out_index: got %0d expected 0", out_index); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    sb_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(N); k++) begin
      send_sample(SW'({$urandom(), $urandom()}), k == 0);
    end
    wait_drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_drain: %0d outputs pending, expected 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_sof_restart();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
